// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: load/store size encodings, LSU state encoding
// and the small decode helpers the load/store unit builds on.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    LSU_IDLE = 3'd0,
    LSU_REQ  = 3'd1,
    LSU_WAIT = 3'd2,
    LSU_DONE = 3'd3,
    LSU_ERR  = 3'd4
  } lsu_state_e;

  // Unsigned sizes are load-only; a store with BU/HU is rejected like a bad size.
  function automatic logic lsu_illegal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] off);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = |off;
      F3_BU:   bad = we;
      F3_HU:   bad = we | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = 4'b0011 << off;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lsu_lane_data(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] d;
    case (f3)
      F3_B, F3_BU: d = {4{wdata[7:0]}};
      F3_H, F3_HU: d = {2{wdata[15:0]}};
      default:     d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and sign- or
// zero-extends it; purely combinational so a cache path can share it.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store sequencer: checks alignment, drives a req/gnt/rvalid
// memory bus with a bounded timer, and returns extended load data.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output lsu_state_e        dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wd_q, wd_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       load_result;
  logic              timed_out;

  lsu_load_align u_load_align (
    .funct3 (f3_q),
    .offset (off_q),
    .word   (bus_rdata),
    .result (load_result)
  );

  assign timed_out = (timer_q == TW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    case (state_q)
      LSU_IDLE: begin
        if (start) begin
          if (lsu_illegal(we, funct3, addr[1:0])) begin
            state_d = LSU_ERR;
          end else begin
            we_d    = we;
            f3_d    = funct3;
            off_d   = addr[1:0];
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            be_d    = lsu_byte_en(funct3, addr[1:0]);
            wd_d    = lsu_lane_data(funct3, wdata);
            timer_d = '0;
            state_d = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        // A load may see its data in the very cycle it is granted.
        if (bus_gnt) begin
          if (we_q) begin
            state_d = LSU_DONE;
          end else if (bus_rvalid) begin
            rdata_d = load_result;
            state_d = LSU_DONE;
          end else begin
            state_d = LSU_WAIT;
          end
        end else if (timed_out) begin
          state_d = LSU_ERR;
        end
        timer_d = timer_q + TW'(1);
      end
      LSU_WAIT: begin
        if (bus_rvalid) begin
          rdata_d = load_result;
          state_d = LSU_DONE;
        end else if (timed_out) begin
          state_d = LSU_ERR;
        end
        timer_d = timer_q + TW'(1);
      end
      LSU_DONE: state_d = LSU_IDLE;
      LSU_ERR:  state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wd_q    <= 32'h0;
      timer_q <= '0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
    end
  end

  // Handshake: bus_req is held with stable addr/be/wdata/we until a cycle with
  // bus_gnt; read data is taken on bus_rvalid only while the access is live.
  assign busy      = (state_q != LSU_IDLE);
  assign done      = (state_q == LSU_DONE);
  assign err       = (state_q == LSU_ERR);
  assign bus_req   = (state_q == LSU_REQ);
  assign bus_we    = (state_q == LSU_REQ) & we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wd_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of accesses with a completion scoreboard,
// plus hand sequences for timeout and reset during an access.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  logic        a_busy, a_done, a_err, a_bus_req, a_bus_we;
  logic [31:0] a_rdata, a_bus_addr, a_bus_wdata;
  logic [3:0]  a_bus_be;
  lsu_state_e  a_state;
  logic        b_busy, b_done, b_err, b_bus_req, b_bus_we;
  logic [31:0] b_rdata, b_bus_addr, b_bus_wdata;
  logic [3:0]  b_bus_be;
  lsu_state_e  b_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model_rd = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start_a), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .busy(a_busy), .done(a_done), .err(a_err), .rdata(a_rdata),
    .bus_req(a_bus_req), .bus_we(a_bus_we), .bus_addr(a_bus_addr), .bus_be(a_bus_be),
    .bus_wdata(a_bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .dbg_state(a_state)
  );

  load_store_unit #(.ADDR_W(32), .TIMEOUT(4)) dut_t4 (
    .clk(clk), .rst(rst), .start(start_b), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .busy(b_busy), .done(b_done), .err(b_err), .rdata(b_rdata),
    .bus_req(b_bus_req), .bus_we(b_bus_we), .bus_addr(b_bus_addr), .bus_be(b_bus_be),
    .bus_wdata(b_bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .dbg_state(b_state)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    int          gnt_dly;
    int          rv_dly;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[15];

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Completion monitor: every done/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && (a_done || a_err)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_completion: done=%b err=%b at %0t", a_done, a_err, $time);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({a_err, a_rdata} !== e) begin
          n_fail++;
          $display("FAIL completion: got err=%b rdata=%h expected err=%b rdata=%h",
                   a_err, a_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata; start_a = 1'b1;
    if (!v.exp_err && !v.we) model_rd = v.exp_rd;
    exp_q.push_back({v.exp_err, model_rd});
    @(posedge clk); #1;
    start_a = 1'b0;
    we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    if (v.exp_err) begin
      check_bit("err_latency", a_err, 1'b1);
      check_bit("err_no_bus_req", a_bus_req, 1'b0);
    end else begin
      for (int k = 0; k <= v.gnt_dly; k++) begin
        check_bit("bus_req", a_bus_req, 1'b1);
        check_bit("bus_we", a_bus_we, v.we);
        check_word("bus_addr", a_bus_addr, v.addr & 32'hFFFF_FFFC);
        check_word("bus_be", 32'(a_bus_be), 32'(v.exp_be));
        if (v.we) check_word("bus_wdata", a_bus_wdata, v.exp_wd);
        bus_gnt = (k == v.gnt_dly);
        if (!v.we && v.rv_dly == 0 && k == v.gnt_dly) begin
          bus_rvalid = 1'b1;
          bus_rdata  = v.word;
        end else begin
          bus_rdata = $urandom;
        end
        @(posedge clk); #1;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
      end
      if (!v.we) begin
        for (int j = 1; j <= v.rv_dly; j++) begin
          check_bit("wait_busy", a_busy, 1'b1);
          check_bit("wait_no_req", a_bus_req, 1'b0);
          bus_rvalid = (j == v.rv_dly);
          bus_rdata  = (j == v.rv_dly) ? v.word : $urandom;
          @(posedge clk); #1;
          bus_rvalid = 1'b0;
        end
      end
      check_bit("done_latency", a_done, 1'b1);
    end
    @(posedge clk); #1;
    check_bit("busy_falls", a_busy, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, F3_B,  32'h1003, 32'h000000A5, 32'h0, 0, 0, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0};
    vecs[1]  = '{1'b0, F3_H,  32'h2002, 32'h0, 32'h80017FFF, 0, 1, 1'b0, 4'b1100, 32'h0, 32'hFFFF8001};
    vecs[2]  = '{1'b0, F3_HU, 32'h2002, 32'h0, 32'h80017FFF, 0, 1, 1'b0, 4'b1100, 32'h0, 32'h00008001};
    vecs[3]  = '{1'b0, F3_W,  32'h3001, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, F3_B,  32'h2001, 32'h0, 32'h123480FF, 3, 2, 1'b0, 4'b0010, 32'h0, 32'hFFFFFF80};
    vecs[5]  = '{1'b0, F3_BU, 32'h2003, 32'h0, 32'hF1000000, 1, 1, 1'b0, 4'b1000, 32'h0, 32'h000000F1};
    vecs[6]  = '{1'b1, F3_H,  32'h6002, 32'hDEADBEEF, 32'h0, 2, 0, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vecs[7]  = '{1'b1, F3_W,  32'h7000, 32'h12345678, 32'h0, 0, 0, 1'b0, 4'b1111, 32'h12345678, 32'h0};
    vecs[8]  = '{1'b0, F3_W,  32'h7004, 32'h0, 32'hCAFEF00D, 0, 0, 1'b0, 4'b1111, 32'h0, 32'hCAFEF00D};
    vecs[9]  = '{1'b1, 3'b011, 32'h1000, 32'h1, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[10] = '{1'b1, F3_H,  32'h0101, 32'h1, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[11] = '{1'b1, F3_BU, 32'h0100, 32'h1, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[12] = '{1'b0, F3_H,  32'h2000, 32'h0, 32'h80017FFF, 0, 1, 1'b0, 4'b0011, 32'h0, 32'h00007FFF};
    vecs[13] = '{1'b0, F3_HU, 32'h2001, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[14] = '{1'b0, F3_B,  32'h2000, 32'h0, 32'hFFFFFF7F, 0, 3, 1'b0, 4'b0001, 32'h0, 32'h0000007F};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_busy", a_busy, 1'b0);
    check_bit("rst_done", a_done, 1'b0);
    check_bit("rst_err", a_err, 1'b0);
    check_bit("rst_bus_req", a_bus_req, 1'b0);
    check_bit("rst_bus_we", a_bus_we, 1'b0);
    check_word("rst_bus_be", 32'(a_bus_be), 32'h0);
    check_word("rst_bus_addr", a_bus_addr, 32'h0);
    check_word("rst_bus_wdata", a_bus_wdata, 32'h0);
    check_word("rst_rdata", a_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    for (int i = 0; i < 6; i++) begin
      vec_t vr;
      logic [1:0] off;
      logic [7:0] b;
      off = 2'($urandom_range(0, 3));
      b   = 8'($urandom_range(0, 255));
      vr  = '{1'b1, F3_B, 32'h8000 | 32'(off), {24'($urandom), b}, 32'h0,
              int'($urandom_range(0, 2)), 0, 1'b0, 4'b0001 << off, {4{b}}, 32'h0};
      run_vec(vr);
    end

    // Timeout on the TIMEOUT=4 instance: load granted, data never returns.
    @(negedge clk);
    we = 1'b0; funct3 = F3_W; addr = 32'h5000; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check_bit("to_req", b_bus_req, 1'b1);
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check_bit("to_no_early_err", b_err, 1'b0);
      check_bit("to_busy", b_busy, 1'b1);
      @(posedge clk); #1;
    end
    check_bit("to_err", b_err, 1'b1);
    check_bit("to_req_dropped", b_bus_req, 1'b0);
    @(posedge clk); #1;
    check_bit("to_idle", b_busy, 1'b0);
    bus_rvalid = 1'b1; bus_rdata = 32'hDEADDEAD;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    check_bit("to_late_rvalid_done", b_done, 1'b0);
    check_bit("to_late_rvalid_busy", b_busy, 1'b0);
    check_word("to_rdata_kept", b_rdata, 32'h0);
    @(negedge clk);
    we = 1'b1; funct3 = F3_W; addr = 32'h5004; wdata = 32'h0BADF00D; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check_bit("to_next_req", b_bus_req, 1'b1);
    check_word("to_next_wdata", b_bus_wdata, 32'h0BADF00D);
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    check_bit("to_next_done", b_done, 1'b1);

    // Reset asserted while a load waits for data.
    @(negedge clk);
    we = 1'b0; funct3 = F3_B; addr = 32'h2000; start_a = 1'b1;
    exp_q.push_back({1'b0, 32'h0});
    @(posedge clk); #1;
    start_a = 1'b0;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    check_word("rw_in_wait", 32'(a_state), 32'(LSU_WAIT));
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_bit("rw_busy", a_busy, 1'b0);
    check_bit("rw_bus_req", a_bus_req, 1'b0);
    check_word("rw_state", 32'(a_state), 32'(LSU_IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_rd = 32'h0;
    begin
      vec_t vs;
      vs = '{1'b1, F3_W, 32'h4000, 32'h13579BDF, 32'h0, 0, 0, 1'b0, 4'b1111, 32'h13579BDF, 32'h0};
      run_vec(vs);
    end

    repeat (2) @(posedge clk);
    check_word("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
